// File: rtl/sync_delay_line.sv
// sync_delay_line: video timing/pixel alignment delay line.
// Ports: pclk/rst, dly_cfg, {de,hs,vs,data}_in -> _out, dly_cur, dly_busy.
module sync_delay_line #(
  parameter int DW          = 16,
  parameter int MAX_DLY     = 8,
  parameter int DLY_W       = 4,
  parameter int DEFAULT_DLY = 1,
  parameter int HS_POL      = 1,
  parameter int VS_POL      = 1
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic [DLY_W-1:0] dly_cfg,
  input  logic             de_in,
  input  logic             hs_in,
  input  logic             vs_in,
  input  logic [DW-1:0]    data_in,
  output logic             de_out,
  output logic             hs_out,
  output logic             vs_out,
  output logic [DW-1:0]    data_out,
  output logic [DLY_W-1:0] dly_cur,
  output logic             dly_busy
);

  localparam int SW = DW + 3;

  localparam logic HS_ACT = (HS_POL != 0);
  localparam logic VS_ACT = (VS_POL != 0);

  localparam logic [DLY_W-1:0] ONE_L = DLY_W'(1);
  localparam logic [DLY_W-1:0] MAX_L = DLY_W'(MAX_DLY);
  localparam logic [DLY_W-1:0] DEF_L =
    (DEFAULT_DLY < 1)       ? ONE_L :
    (DEFAULT_DLY > MAX_DLY) ? MAX_L :
    DLY_W'(DEFAULT_DLY);

  // Stage word: {de, hs, vs, data}; idle = inactive syncs, no data.
  localparam logic [SW-1:0] IDLE =
    {1'b0, ~HS_ACT, ~VS_ACT, {DW{1'b0}}};

  function automatic logic [DLY_W-1:0] clamp_dly(
    input logic [DLY_W-1:0] x
  );
    logic [DLY_W-1:0] r;
    unique case (1'b1)
      (x == '0):   r = ONE_L;
      (x > MAX_L): r = MAX_L;
      default:     r = x;
    endcase
    return r;
  endfunction

  logic [SW-1:0]    stg_q [MAX_DLY];
  logic [SW-1:0]    stg_d [MAX_DLY];
  logic [DLY_W-1:0] dly_cur_q, dly_cur_d;
  logic [DLY_W-1:0] mask_q, mask_d;
  logic             vs_prev_q, vs_prev_d;

  logic [DLY_W-1:0] cfg_c;
  logic [DLY_W-1:0] mask_ld;
  logic             vs_act;
  logic             vs_lead;
  logic             req;
  logic             mask_on;
  logic [SW-1:0]    sel;

  always_comb begin
    cfg_c   = clamp_dly(dly_cfg);
    vs_act  = (vs_in == VS_ACT);
    vs_lead = vs_act & ~vs_prev_q;
    req     = (cfg_c != dly_cur_q);
    mask_on = (mask_q != '0);
    // Mask long enough to flush whichever path is longer.
    mask_ld = (cfg_c > dly_cur_q) ? cfg_c : dly_cur_q;
  end

  always_comb begin
    stg_d[0] = {de_in, hs_in, vs_in, data_in};
    for (int i = 1; i < MAX_DLY; i++) begin
      stg_d[i] = stg_q[i-1];
    end
  end

  always_comb begin
    vs_prev_d = vs_act;
    dly_cur_d = dly_cur_q;
    mask_d    = mask_on ? mask_q - ONE_L : mask_q;
    // Switch only at a VS leading edge; a reload
    // during an active mask restarts the flush.
    if (vs_lead && req) begin
      dly_cur_d = cfg_c;
      mask_d    = mask_ld;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      for (int i = 0; i < MAX_DLY; i++) begin
        stg_q[i] <= IDLE;
      end
      dly_cur_q <= DEF_L;
      mask_q    <= '0;
      vs_prev_q <= 1'b0;
    end else begin
      for (int i = 0; i < MAX_DLY; i++) begin
        stg_q[i] <= stg_d[i];
      end
      dly_cur_q <= dly_cur_d;
      mask_q    <= mask_d;
      vs_prev_q <= vs_prev_d;
    end
  end

  // Tap select: stage[dly_cur-1].
  always_comb begin
    sel = IDLE;
    for (int i = 0; i < MAX_DLY; i++) begin
      if (dly_cur_q == DLY_W'(i + 1)) begin
        sel = stg_q[i];
      end
    end
  end

  always_comb begin
    de_out   = sel[SW-1] & ~mask_on;
    hs_out   = sel[SW-2];
    vs_out   = sel[SW-3];
    data_out = mask_on ? '0 : sel[DW-1:0];
    dly_cur  = dly_cur_q;
    dly_busy = req | mask_on;
  end

endmodule
